vip_frame_stream_gen_8bit: RTL

Frame-timing transmitter producing the 8-bit `vsync`/`href`/`clken` pixel-stream protocol that the 3x3 window generators and downstream VIP filters consume. It pulls grey pixels from an upstream valid/ready source, typically a frame-buffer read FIFO. It emits them in raster order with programmable vertical and horizontal blanking. Its main uses are driving the HumanDetector pipeline from DDR readback and acting as the bench stimulus source for window-based filters.

---
 rtl/vip_frame_stream_gen_8bit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vip_frame_stream_gen_8bit.sv
// Raster frame-timing transmitter: pulls grey pixels from a valid/ready source and emits vsync/href/clken.
// Define VIP_TEST_PATTERN_EN to ignore the input and emit an (x + y) diagonal ramp instead.
module vip_frame_stream_gen_8bit #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int H_BLANK   = 160,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 2,
    parameter int V_FRONT   = 2,
    parameter int CLKEN_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_y,
    output logic       frame_done,
    output logic       underflow
);

    localparam int HWIN  = H_ACTIVE * CLKEN_DIV;
    localparam int LINE  = HWIN + H_BLANK;
    localparam int VM_A  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int VM_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int VMAX  = (VM_A > VM_B) ? VM_A : VM_B;
    localparam int HC_W  = $clog2(LINE);
    localparam int VC_W  = $clog2(VMAX + 1);
    localparam int DV_W  = $clog2(CLKEN_DIV + 1);
    localparam int XC_W  = $clog2(H_ACTIVE + 1);
    localparam int YC_W  = $clog2(V_ACTIVE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t            state, state_n;
    logic [HC_W-1:0]   hcnt, hcnt_n;
    logic [VC_W-1:0]   vcnt, vcnt_n, vlast;
    logic [DV_W-1:0]   div, div_n;
    logic [XC_W-1:0]   xcnt, xcnt_n;
    logic [YC_W-1:0]   ycnt, ycnt_n;
    logic              line_end, href_cur, slot_cur;
    logic              href_n, slot_n, last_n;

    always_comb begin
        vlast = '0;
        case (state)
            S_VSYNC:  vlast = VC_W'(V_SYNC - 1);
            S_VBACK:  vlast = VC_W'(V_BACK - 1);
            S_ACTIVE: vlast = VC_W'(V_ACTIVE - 1);
            S_VFRONT: vlast = VC_W'(V_FRONT - 1);
            default:  vlast = '0;
        endcase
    end

    // Next-cycle timing state; outputs are registered from these so they line up with the counters.
    always_comb begin
        state_n  = state;
        hcnt_n   = hcnt;
        vcnt_n   = vcnt;
        div_n    = div;
        xcnt_n   = xcnt;
        ycnt_n   = ycnt;
        line_end = (hcnt == HC_W'(LINE - 1));
        href_cur = (state == S_ACTIVE) && (hcnt < HC_W'(HWIN));
        slot_cur = href_cur && (div == DV_W'(CLKEN_DIV - 1));
        if (state == S_IDLE) begin
            hcnt_n = '0;
            vcnt_n = '0;
            div_n  = '0;
            xcnt_n = '0;
            ycnt_n = '0;
            if (enable) begin
                state_n = S_VSYNC;
            end
        end else begin
            hcnt_n = line_end ? '0 : hcnt + HC_W'(1);
            div_n  = (href_cur && (div != DV_W'(CLKEN_DIV - 1))) ? div + DV_W'(1) : '0;
            if (slot_cur) begin
                xcnt_n = (xcnt == XC_W'(H_ACTIVE - 1)) ? '0 : xcnt + XC_W'(1);
            end
            if (line_end) begin
                if (state == S_ACTIVE) begin
                    ycnt_n = (ycnt == YC_W'(V_ACTIVE - 1)) ? '0 : ycnt + YC_W'(1);
                end
                if (vcnt == vlast) begin
                    vcnt_n = '0;
                    case (state)
                        S_VSYNC:  state_n = (V_BACK == 0) ? S_ACTIVE : S_VBACK;
                        S_VBACK:  state_n = S_ACTIVE;
                        S_ACTIVE: state_n = (V_FRONT == 0) ? (enable ? S_VSYNC : S_IDLE) : S_VFRONT;
                        S_VFRONT: state_n = enable ? S_VSYNC : S_IDLE;
                        default:  state_n = S_IDLE;
                    endcase
                end else begin
                    vcnt_n = vcnt + VC_W'(1);
                end
            end
        end
    end

    always_comb begin
        href_n = (state_n == S_ACTIVE) && (hcnt_n < HC_W'(HWIN));
        slot_n = href_n && (div_n == DV_W'(CLKEN_DIV - 1));
        if (V_FRONT == 0) begin
            last_n = (state_n == S_ACTIVE) && (vcnt_n == VC_W'(V_ACTIVE - 1))
                     && (hcnt_n == HC_W'(LINE - 1));
        end else begin
            last_n = (state_n == S_VFRONT) && (vcnt_n == VC_W'(V_FRONT - 1))
                     && (hcnt_n == HC_W'(LINE - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            hcnt  <= '0;
            vcnt  <= '0;
            div   <= '0;
            xcnt  <= '0;
            ycnt  <= '0;
        end else begin
            state <= state_n;
            hcnt  <= hcnt_n;
            vcnt  <= vcnt_n;
            div   <= div_n;
            xcnt  <= xcnt_n;
            ycnt  <= ycnt_n;
        end
    end

    logic [7:0] pix_n;

`ifdef VIP_TEST_PATTERN_EN
    logic unused_inputs;
    assign unused_inputs = ^{in_valid, in_data, enable_unused_guard()};
    function automatic logic enable_unused_guard();
        return 1'b0;
    endfunction
    assign in_ready = 1'b0;
    assign pix_n    = 8'(32'(xcnt_n) + 32'(ycnt_n));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else begin
            underflow <= 1'b0;
        end
    end
`else
    logic enable_d;

    // The slot's strobe is registered, so the source is asked one cycle ahead of it.
    assign in_ready = slot_n;
    assign pix_n    = in_valid ? in_data : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_d  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            enable_d <= enable;
            if (enable && !enable_d) begin
                underflow <= 1'b0;
            end else if (in_ready && !in_valid) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_y       <= 8'd0;
            frame_done       <= 1'b0;
        end else begin
            post_frame_vsync <= (state_n == S_VSYNC);
            post_frame_href  <= href_n;
            post_frame_clken <= slot_n;
            frame_done       <= last_n;
            if (slot_n) begin
                post_img_y <= pix_n;
            end else if (!href_n) begin
                post_img_y <= 8'd0;
            end
        end
    end

endmodule
